// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_pkg
//  Description : Shared helpers for the register-file writeback arbiter.
//                - safe_clog2 sizes addresses and the round-robin pointer
//                  (never returns less than 1 bit).
//                - `REGFILE_WB_DECLARE_REQ_S builds the per-requester write
//                  request struct (v, addr, data) at the widths chosen by
//                  the instantiating module.
//  Revision    : 1.0 - initial release
// ============================================================================

// The request struct depends on module parameters, which a package cannot
// see. A declaration macro lets each module build the struct at its own
// widths.
`define REGFILE_WB_DECLARE_REQ_S(width_mp, addr_width_mp) \
    typedef struct packed {                                \
        logic                     v;                       \
        logic [(addr_width_mp)-1:0] addr;                  \
        logic [(width_mp)-1:0]      data;                  \
    } regfile_wb_req_s

package regfile_wb_pkg;

    // Address/pointer width that stays legal for a single-entry space.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_rr_arb
//  Description : Combinational round-robin grant for the writeback arbiter.
//                The search starts at i_ptr and wraps. With hi_prio_0_p = 1,
//                requester 0 wins whenever it is valid and the rotating
//                search covers only requesters 1..num_req_p-1.
//  Ports       : i_req        request vector
//                i_ptr        current round-robin pointer
//                o_grant      one-hot grant
//                o_grant_v    any grant this cycle
//                o_grant_idx  index of the granted requester
//                o_next_ptr   pointer value to load when a grant happens
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_rr_arb
    import regfile_wb_pkg::*;
#(
    parameter int num_req_p    = 3,
    parameter int ptr_width_lp = safe_clog2(num_req_p),
    parameter int hi_prio_0_p  = 0
) (
    input  logic [num_req_p-1:0]    i_req,
    input  logic [ptr_width_lp-1:0] i_ptr,
    output logic [num_req_p-1:0]    o_grant,
    output logic                    o_grant_v,
    output logic [ptr_width_lp-1:0] o_grant_idx,
    output logic [ptr_width_lp-1:0] o_next_ptr
);

    // Rotating range: [c_base, num_req_p-1]
    localparam int c_base = (hi_prio_0_p != 0) ? 1 : 0;
    localparam int c_span = num_req_p - c_base;

    int w_start;
    int w_nxt;

    always_comb begin
        o_grant     = '0;
        o_grant_v   = 1'b0;
        o_grant_idx = '0;
        o_next_ptr  = i_ptr;
        w_nxt       = 0;
        // Offset of the pointer within the rotating range. With the priority
        // lane the reset value 0 is outside the range and means "start at 1".
        if (hi_prio_0_p != 0) begin
            w_start = (i_ptr == '0) ? 0 : int'(i_ptr) - 1;
        end else begin
            w_start = int'(i_ptr);
        end

        if ((hi_prio_0_p != 0) && i_req[0]) begin
            // Priority grant leaves the pointer where it is.
            o_grant[0] = 1'b1;
            o_grant_v  = 1'b1;
        end else begin
            for (int k = 0; k < c_span; k++) begin
                for (int j = c_base; j < num_req_p; j++) begin
                    if (!o_grant_v && i_req[j] &&
                        (j == c_base + ((w_start + k) % c_span))) begin
                        o_grant[j]  = 1'b1;
                        o_grant_v   = 1'b1;
                        o_grant_idx = ptr_width_lp'(j);
                        w_nxt       = (j + 1 == num_req_p) ? c_base : j + 1;
                        o_next_ptr  = ptr_width_lp'(w_nxt);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the single register-file write port among num_req_p
//                writeback requesters with round-robin arbitration. The
//                granted write is registered and presented to the regfile
//                one cycle after the grant. Writes to register 0 are
//                consumed and dropped when x0_tied_to_zero_p = 1.
//                Optional pending-write scoreboard, enabled by defining
//                REGFILE_WB_SCOREBOARD_EN; otherwise sb_busy_o is all 0 and
//                the sb_set_* inputs are ignored.
//  Ports       : clk_i          clock
//                reset_n_i      synchronous active-low reset
//                req_v_i        per-requester write pending
//                req_addr_i     per-requester destination (flattened)
//                req_data_i     per-requester data (flattened)
//                req_yumi_o     one-hot grant / request consumed
//                w_v_o          regfile write enable
//                w_addr_o       regfile write address
//                w_data_o       regfile write data
//                sb_set_v_i     mark a destination pending
//                sb_set_addr_i  destination being marked
//                sb_busy_o      pending bit per register
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int num_req_p         = 3,
    parameter int x0_tied_to_zero_p = 1,
    parameter int hi_prio_0_p       = 0,
    parameter int addr_width_lp     = safe_clog2(els_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
    input  logic [num_req_p*width_p-1:0]     req_data_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic                             w_v_o,
    output logic [addr_width_lp-1:0]         w_addr_o,
    output logic [width_p-1:0]               w_data_o,
    input  logic                             sb_set_v_i,
    input  logic [addr_width_lp-1:0]         sb_set_addr_i,
    output logic [els_p-1:0]                 sb_busy_o
);

    localparam int c_ptr_width = safe_clog2(num_req_p);

    `REGFILE_WB_DECLARE_REQ_S(width_p, addr_width_lp);

    regfile_wb_req_s          w_req [num_req_p];
    logic [num_req_p-1:0]     w_req_v;
    logic [num_req_p-1:0]     w_gnt;
    logic                     w_gnt_v;
    logic [c_ptr_width-1:0]   w_gnt_idx;
    logic [c_ptr_width-1:0]   w_next_ptr;
    logic [addr_width_lp-1:0] w_gnt_addr;
    logic [width_p-1:0]       w_gnt_data;
    logic                     w_gnt_drop;
    logic [c_ptr_width-1:0]   r_ptr;
    logic                     r_w_v;
    logic [addr_width_lp-1:0] r_w_addr;
    logic [width_p-1:0]       r_w_data;

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_req
            assign w_req[gi].v    = req_v_i[gi];
            assign w_req[gi].addr = req_addr_i[gi*addr_width_lp +: addr_width_lp];
            assign w_req[gi].data = req_data_i[gi*width_p +: width_p];
            assign w_req_v[gi]    = w_req[gi].v;
        end
    endgenerate

    regfile_wb_rr_arb #(
        .num_req_p    (num_req_p),
        .ptr_width_lp (c_ptr_width),
        .hi_prio_0_p  (hi_prio_0_p)
    ) u_rr_arb (
        .i_req       (w_req_v),
        .i_ptr       (r_ptr),
        .o_grant     (w_gnt),
        .o_grant_v   (w_gnt_v),
        .o_grant_idx (w_gnt_idx),
        .o_next_ptr  (w_next_ptr)
    );

    assign w_gnt_addr = w_req[w_gnt_idx].addr;
    assign w_gnt_data = w_req[w_gnt_idx].data;

    // A granted write to register 0 is still consumed, but never reaches
    // the regfile when x0 is hardwired.
    assign w_gnt_drop = (x0_tied_to_zero_p != 0) && (w_gnt_addr == '0);

    // No requester may believe it was consumed while reset is held.
    assign req_yumi_o = reset_n_i ? w_gnt : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ptr <= '0;
        end else if (w_gnt_v) begin
            r_ptr <= w_next_ptr;
        end
    end

    // Output stage; address/data hold their last value while idle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_w_v    <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_w_v <= w_gnt_v && !w_gnt_drop;
            if (w_gnt_v && !w_gnt_drop) begin
                r_w_addr <= w_gnt_addr;
                r_w_data <= w_gnt_data;
            end
        end
    end

    assign w_v_o    = r_w_v;
    assign w_addr_o = r_w_addr;
    assign w_data_o = r_w_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [els_p-1:0] r_sb_busy;
    logic             w_sb_set_ok;

    // Register 0 can never be pending when it is hardwired.
    assign w_sb_set_ok = sb_set_v_i &&
                         !((x0_tied_to_zero_p != 0) && (sb_set_addr_i == '0));

    // Set is checked before clear so a new op issued to a register in the
    // same cycle its previous result retires remains outstanding.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_sb_busy <= '0;
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (w_sb_set_ok && (sb_set_addr_i == addr_width_lp'(i))) begin
                    r_sb_busy[i] <= 1'b1;
                end else if (w_gnt_v && (w_gnt_addr == addr_width_lp'(i))) begin
                    r_sb_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign sb_busy_o = r_sb_busy;
`else
    logic w_sb_unused;
    assign w_sb_unused = ^{sb_set_v_i, sb_set_addr_i};
    assign sb_busy_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter.
//                dut    : 3 requesters, round-robin, x0 hardwired.
//                dut_hp : same, with requester 0 as priority lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int c_w   = 16;
    localparam int c_els = 16;
    localparam int c_n   = 3;
    localparam int c_aw  = 4;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit c_sb_en = 1'b1;
`else
    localparam bit c_sb_en = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic [c_n-1:0]     req_v;
    logic [c_n*c_aw-1:0] req_addr;
    logic [c_n*c_w-1:0] req_data;
    logic [c_n-1:0]     yumi;
    logic               w_v;
    logic [c_aw-1:0]    w_addr;
    logic [c_w-1:0]     w_data;
    logic               sb_set_v;
    logic [c_aw-1:0]    sb_set_addr;
    logic [c_els-1:0]   sb_busy;

    logic [c_n-1:0]     hp_req_v;
    logic [c_n*c_aw-1:0] hp_req_addr;
    logic [c_n*c_w-1:0] hp_req_data;
    logic [c_n-1:0]     hp_yumi;
    logic               hp_w_v;
    logic [c_aw-1:0]    hp_w_addr;
    logic [c_w-1:0]     hp_w_data;
    logic [c_els-1:0]   hp_busy;
    logic               hp_sb_v = 1'b0;
    logic [c_aw-1:0]    hp_sb_addr = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .width_p(c_w), .els_p(c_els), .num_req_p(c_n),
        .x0_tied_to_zero_p(1), .hi_prio_0_p(0)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(req_v), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_yumi_o(yumi),
        .w_v_o(w_v), .w_addr_o(w_addr), .w_data_o(w_data),
        .sb_set_v_i(sb_set_v), .sb_set_addr_i(sb_set_addr),
        .sb_busy_o(sb_busy)
    );

    regfile_wb_arbiter #(
        .width_p(c_w), .els_p(c_els), .num_req_p(c_n),
        .x0_tied_to_zero_p(1), .hi_prio_0_p(1)
    ) dut_hp (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(hp_req_v), .req_addr_i(hp_req_addr), .req_data_i(hp_req_data),
        .req_yumi_o(hp_yumi),
        .w_v_o(hp_w_v), .w_addr_o(hp_w_addr), .w_data_o(hp_w_data),
        .sb_set_v_i(hp_sb_v), .sb_set_addr_i(hp_sb_addr),
        .sb_busy_o(hp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Set requester i's address and data.
    task automatic set_req(input int i, input logic [c_aw-1:0] a, input logic [c_w-1:0] d);
        req_addr[i*c_aw +: c_aw] = a;
        req_data[i*c_w +: c_w]   = d;
    endtask

    initial begin
        reset_n     = 1'b0;
        req_v       = '0;
        req_addr    = '0;
        req_data    = '0;
        sb_set_v    = 1'b0;
        sb_set_addr = '0;
        hp_req_v    = '0;
        hp_req_addr = {4'd3, 4'd2, 4'd1};
        hp_req_data = {16'h0333, 16'h0222, 16'h0111};

        // ---------------- reset with all requesters valid ----------------
        @(negedge clk);
        req_v = 3'b111;
        set_req(0, 4'd5, 16'h0105);
        set_req(1, 4'd6, 16'h0106);
        set_req(2, 4'd7, 16'h0107);
        repeat (2) begin
            #1;
            chk("rst_yumi", 32'(yumi), 32'h0);
            @(negedge clk);
            chk("rst_w_v", 32'(w_v), 32'h0);
            chk("rst_w_addr", 32'(w_addr), 32'h0);
            chk("rst_w_data", 32'(w_data), 32'h0);
            chk("rst_busy", 32'(sb_busy), 32'h0);
        end

        // ---------------- fairness: 0,1,2,0,1,2 ----------------
        reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("rr_yumi", 32'(yumi), 32'(1 << (n % 3)));
            if (n == 0) begin
                chk("rr_w_v0", 32'(w_v), 32'h0);
            end else begin
                chk("rr_w_v", 32'(w_v), 32'h1);
                chk("rr_w_addr", 32'(w_addr), 32'(5 + (n - 1) % 3));
                chk("rr_w_data", 32'(w_data), 32'(16'h0105 + (n - 1) % 3));
            end
            @(negedge clk);
        end
        req_v = '0;
        #1;
        chk("rr_last_w_addr", 32'(w_addr), 32'h7);
        chk("idle_yumi", 32'(yumi), 32'h0);
        @(negedge clk);
        chk("idle_w_v", 32'(w_v), 32'h0);
        chk("idle_hold_addr", 32'(w_addr), 32'h7);
        chk("idle_hold_data", 32'(w_data), 32'h0107);

        // ---------------- x0 drop (pointer is 0) ----------------
        req_v = 3'b010;
        set_req(1, 4'd0, 16'hDEAD);
        #1;
        chk("x0_yumi", 32'(yumi), 32'h2);
        @(negedge clk);
        chk("x0_w_v", 32'(w_v), 32'h0);
        chk("x0_hold_addr", 32'(w_addr), 32'h7);
        // Pointer advanced to 2: with all valid, requester 2 wins.
        req_v = 3'b111;
        set_req(1, 4'd6, 16'h0106);
        #1;
        chk("x0_ptr_adv", 32'(yumi), 32'h4);
        @(negedge clk);
        req_v = '0;
        chk("x0_next_w_addr", 32'(w_addr), 32'h7);

        // ---------------- scoreboard (pointer is 0) ----------------
        sb_set_v    = 1'b1;
        sb_set_addr = 4'd9;
        @(negedge clk);
        sb_set_v = 1'b0;
        #1;
        chk("sb_set9", 32'(sb_busy), c_sb_en ? 32'h0200 : 32'h0);
        req_v = 3'b010;
        set_req(1, 4'd9, 16'h0909);
        #1;
        chk("sb_clr_yumi", 32'(yumi), 32'h2);
        @(negedge clk);
        req_v = '0;
        #1;
        chk("sb_clr9", 32'(sb_busy), 32'h0);
        chk("sb_wr_v", 32'(w_v), 32'h1);
        chk("sb_wr_addr", 32'(w_addr), 32'h9);
        chk("sb_wr_data", 32'(w_data), 32'h0909);
        // Same-cycle set and clear of 9 (pointer is 2).
        req_v       = 3'b100;
        set_req(2, 4'd9, 16'h0A09);
        sb_set_v    = 1'b1;
        sb_set_addr = 4'd9;
        #1;
        chk("sb_same_yumi", 32'(yumi), 32'h4);
        @(negedge clk);
        req_v    = '0;
        sb_set_v = 1'b0;
        #1;
        chk("sb_same_busy", 32'(sb_busy), c_sb_en ? 32'h0200 : 32'h0);
        chk("sb_same_w_data", 32'(w_data), 32'h0A09);
        // Different addresses: set 3, clear 9 via requester 0 (pointer 0).
        req_v       = 3'b001;
        set_req(0, 4'd9, 16'h0B09);
        sb_set_v    = 1'b1;
        sb_set_addr = 4'd3;
        #1;
        chk("sb_diff_yumi", 32'(yumi), 32'h1);
        @(negedge clk);
        req_v       = '0;
        sb_set_addr = 4'd0;
        #1;
        chk("sb_diff_busy", 32'(sb_busy), c_sb_en ? 32'h0008 : 32'h0);
        // Set of register 0 is ignored.
        @(negedge clk);
        sb_set_v = 1'b0;
        #1;
        chk("sb_x0_set", 32'(sb_busy), c_sb_en ? 32'h0008 : 32'h0);

        // ---------------- priority lane (dut_hp) ----------------
        for (int n = 0; n < 6; n++) begin
            hp_req_v = {2'b11, (n % 2 == 0)};
            #1;
            case (n)
                0, 2, 4: chk("hp_yumi_r0", 32'(hp_yumi), 32'h1);
                1, 5:    chk("hp_yumi_r1", 32'(hp_yumi), 32'h2);
                default: chk("hp_yumi_r2", 32'(hp_yumi), 32'h4);
            endcase
            @(negedge clk);
        end
        hp_req_v = '0;
        #1;
        chk("hp_w_addr", 32'(hp_w_addr), 32'h2);
        chk("hp_busy", 32'(hp_busy), 32'h0);

        // ---------------- reset mid-operation ----------------
        req_v = 3'b111;
        set_req(0, 4'd5, 16'h0105);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_yumi", 32'(yumi), 32'h0);
        @(negedge clk);
        chk("midrst_w_v", 32'(w_v), 32'h0);
        chk("midrst_busy", 32'(sb_busy), 32'h0);
        reset_n = 1'b1;
        #1;
        chk("midrst_ptr0", 32'(yumi), 32'h1);
        @(negedge clk);
        req_v = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among `num_req_p` writeback requesters (core pipeline, FPU, remote-load return, etc.) using round-robin arbitration.
- Drives the regfile `w_v/w_addr/w_data` from a registered stage.
- Optionally keeps a pending-write scoreboard so issue logic can stall on registers still awaiting long-latency writeback.
- Sits between the execute/writeback requesters and the regfile instance.

Parameters:
- width_p, "inv", data width; must match the regfile.
- els_p, "inv", number of registers.
- num_req_p, "inv", number of writeback requesters; >= 2.
- x0_tied_to_zero_p, "inv", 1 = register 0 is hardwired; writes to it are consumed and dropped.
- hi_prio_0_p, 0, 1 = requester 0 always wins when valid; remaining requesters share round-robin.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`, register address width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset: one clock, reset is synchronous and active-low
- req_v_i  in  num_req_p  requester has a write pending
- req_addr_i  in  num_req_p x addr_width_lp  destination register per requester
- req_data_i  in  num_req_p x width_p  write data per requester
- req_yumi_o  out  num_req_p  one-hot grant; request consumed this cycle
- w_v_o  out  1  regfile write enable
- w_addr_o  out  addr_width_lp  regfile write address
- w_data_o  out  width_p  regfile write data
- sb_set_v_i  in  1  long-latency op issued; mark destination pending
- sb_set_addr_i  in  addr_width_lp  destination being marked
- sb_busy_o  out  els_p  pending bit per register

Behaviour:
- Reset (`reset_n_i`=0 at a rising edge):
  - `w_v_o`=0, `w_addr_o`=0, `w_data_o`=0.
  - RR pointer=0, `sb_busy_o`=all 0.
  - `req_yumi_o`=0 combinationally while reset is low.
- Grant:
  - Combinational, at most one `req_yumi_o` bit set per cycle.
  - `req_yumi_o[i]` is set only if `req_v_i[i]`=1.
  - Requesters must hold v/addr/data stable until yumi.
- Round-robin:
  - Search starts at the pointer index and wraps at `num_req_p`-1 -> 0.
  - After a grant to index g, pointer <= (g+1) mod `num_req_p`.
  - Pointer is unchanged when there is no grant.
- `hi_prio_0_p`=1: `req_v_i[0]` wins unconditionally. The pointer only covers 1..`num_req_p`-1 and is not advanced by a requester-0 grant.
- Latency: a grant in cycle t produces `w_v_o`/`w_addr_o`/`w_data_o` in cycle t+1 from the output register.
  - The write port is always ready, so there is no backpressure.
  - `w_addr_o`/`w_data_o` hold their last value when `w_v_o`=0.
- x0 drop: if `x0_tied_to_zero_p`=1 and the granted address is 0:
  - yumi is still asserted and the pointer still advances.
  - `w_v_o` stays 0 in t+1.
- Scoreboard:
  - Set: `sb_set_v_i` sets `busy[sb_set_addr_i]` at the next edge.
  - Clear: any grant (including a dropped x0 grant) clears `busy[addr]` at the next edge.
  - Set and clear of the same address in the same cycle: set wins (a new op is outstanding).
  - Set and clear of different addresses in the same cycle: both take effect.
  - Set to address 0 with `x0_tied_to_zero_p`=1 is ignored; `busy[0]` remains 0.
  - Set of an already-busy register: stays 1 (no counting; one outstanding op per register).
  - Clear of a non-busy register: no effect.
- Reset mid-operation: the in-flight output-register write is discarded (`w_v_o`=0 the cycle after reset is sampled); the scoreboard is cleared.

Optional Feature:
- Macro: REGFILE_WB_SCOREBOARD_EN.
- Defined: scoreboard flops and `sb_*` behaviour as above.
- Not defined:
  - No scoreboard flops.
  - `sb_busy_o` tied to all 0.
  - `sb_set_v_i`/`sb_set_addr_i` ignored.
  - Arbitration and write timing identical.

Decomposition:
- Shared package `regfile_wb_pkg` holds:
  - `regfile_wb_req_s` typedef (v, addr, data), parameterised through the module's widths.
  - Localparam for the pointer width `BSG_SAFE_CLOG2(num_req_p)`.
- One natural sub-module: `regfile_wb_rr_arb`.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, granted index and next pointer.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: hold `reset_n_i`=0 two cycles with all `req_v_i`=1 -> `req_yumi_o`=0, `w_v_o`=0, `sb_busy_o`=0; first cycle after release -> grant to requester 0.
- Fairness: `num_req_p`=3, all three valid continuously with addr 5/6/7 -> yumi order 0,1,2,0,1,2; `w_addr_o` 5,6,7,5,... each one cycle after its grant.
- Priority, `hi_prio_0_p`=1:
  - req0 valid every other cycle, req1/req2 always valid -> req0 granted whenever valid.
  - Gaps alternate req1, req2.
- x0 drop, `x0_tied_to_zero_p`=1: single request addr 0 data 0xDEAD -> yumi=1, next-cycle `w_v_o`=0, pointer advances.
- Scoreboard set/clear (macro on):
  - `sb_set` addr 9 -> `busy[9]`=1 next cycle.
  - Later req1 writeback to addr 9 granted -> `busy[9]`=0 next cycle.
  - Same-cycle set 9 and grant to 9 -> `busy[9]`=1.
- Macro off: same stimulus as the scoreboard test -> `sb_busy_o` stays 0, write sequence unchanged.
